icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache. It is the responder end of the instruction half of the datapath-cache interface.
- Answers pipeline fetches (imemREN/imemaddr) with ihit/imemload.
- On a miss, it issues single-word read requests to the memory controller (iREN/iaddr, answered by iwait/iload) and fills the frame.
- Sits between the datapath and the memory controller, alongside the data cache.

Parameters:
- NSETS, 16, number of frames (power of two, minimum 2).
- WORD_W, 32, instruction/data word width.
- ADDR_W, 32, byte address width. Fields: offset [1:0] (ignored), index [IDX_W+1:2], tag [ADDR_W-1:IDX_W+2], where IDX_W = log2(NSETS).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  ADDR_W  fetch byte address.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  WORD_W  fetched instruction.
- iREN  out  1  read request to memory controller.
- iaddr  out  ADDR_W  word-aligned read address to memory controller.
- iwait  in  1  memory busy; the fill word is valid when iwait=0 while iREN=1.
- iload  in  WORD_W  fill data from memory controller.
- invalidate  in  1  clear all valid bits (halt/flush).

Behaviour:
- Reset (async, RST=1): all valid bits 0, tags and data 0, state IDLE, latched miss address 0. Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- Frame: {valid, tag[ADDR_W-IDX_W-2], data[WORD_W]}.
- States:
  - IDLE: lookup active. hit = imemREN & valid[idx] & (tag[idx]==addr tag). ihit=hit combinationally (zero-cycle hit). imemload = data[idx] when hit, else 0. iREN=0.
  - IDLE to MISS: on imemREN & !hit & !invalidate. Register miss_addr = {imemaddr[ADDR_W-1:2], 2'b00} at that edge.
  - MISS: ihit=0, imemload=0, iREN=1, iaddr=miss_addr. No lookup is performed.
  - MISS to IDLE: on iwait=0. At that edge, write frame[miss_addr idx] = {1, miss_addr tag, iload}.
- Latency:
  - Hit: same cycle.
  - Miss with N wait cycles: 1 detect cycle + N+1 MISS cycles. ihit asserts in the following IDLE cycle if the request is unchanged.
- Boundary conditions:
  - imemREN deasserted during MISS (datapath doing a dmem access): the fill still completes. iREN is never aborted mid-request.
  - imemaddr changes during MISS (branch/jump redirect): fill of the latched miss_addr completes. The new address is looked up in the next IDLE cycle.
  - Conflict: fill overwrites the frame at that index unconditionally (direct-mapped replacement).
  - imemaddr[1:0] nonzero: ignored; the aligned word is returned.
  - invalidate in IDLE: all valid bits cleared at the edge. Lookup in the same cycle still uses pre-clear state. No miss is started that cycle.
  - invalidate in MISS: the fill still ends the request (state returns to IDLE) but the frame is written with valid=0. invalidate wins over the fill.
  - invalidate and imemREN with a hit in the same cycle: ihit=1 this cycle; the frame is invalid from next cycle.
  - RST mid-MISS: immediate return to IDLE with iREN=0. No frame is written.
- All registers are updated only on the CLK rising edge, except asynchronous reset.

Decomposition:
- Shared package icache_pkg:
  - IDX_W and TAG_W localparams, derived from NSETS/ADDR_W.
  - icache_frame_t packed struct {valid, tag, data}.
  - icache_state_t enum {IDLE, MISS}.
  - Address-field extraction functions get_idx and get_tag.
- No sub-module. The frame array and the two-state FSM live in one module.

Test Plan:
- Reset: assert RST mid-simulation -> ihit=0, iREN=0, iaddr=0, imemload=0; next fetch of any address misses.
- Cold miss: imemREN=1, imemaddr=0x100, iwait=1 for 3 cycles then 0 with iload=0xDEADBEEF.
  - iREN=1, iaddr=0x100 for 4 cycles.
  - Following cycle: ihit=1, imemload=0xDEADBEEF.
  - Refetch of 0x102 -> hit with the same data.
- Conflict eviction: after the fill above, fetch 0x140 (same index 0), fill 0x12345678 -> hit on 0x140; refetch 0x100 -> miss, iREN=1, iaddr=0x100.
- Redirect mid-miss: miss on 0x200; change imemaddr to 0x300 and drop imemREN for 2 cycles during iwait.
  - Fill of 0x200 completes.
  - Then a new miss on 0x300 with iaddr=0x300.
  - Afterwards 0x200 hits.
- Invalidate during fill: invalidate=1 on the cycle iwait falls for 0x400 -> state returns to IDLE and the refetch of 0x400 misses. Separately, invalidate in IDLE -> previously cached 0x100 misses on the next cycle.
- Hit timing: with 0x100 cached, toggle imemREN 1/0/1 -> ihit follows imemREN the same cycle, iREN stays 0.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
package icache_pkg;
  localparam int NSETS  = 16;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = $clog2(NSETS);
  localparam int TAG_W  = ADDR_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WORD_W-1:0] data;
  } icache_frame_t;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} icache_state_t;

  // Byte offset is dropped by the shift; width cast keeps the index bits.
  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> 2);
  endfunction

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (IDX_W + 2));
  endfunction
endpackage

// File: rtl/icache_responder_if.sv
// Fetch port (datapath side) and fill port (memory-controller side) bundled.
interface icache_responder_if;
  logic                          imemREN;
  logic [icache_pkg::ADDR_W-1:0] imemaddr;
  logic                          ihit;
  logic [icache_pkg::WORD_W-1:0] imemload;
  logic                          iREN;
  logic [icache_pkg::ADDR_W-1:0] iaddr;
  logic                          iwait;
  logic [icache_pkg::WORD_W-1:0] iload;
  logic                          invalidate;

  // Cache end.
  modport slave (
    input  imemREN, imemaddr, iwait, iload, invalidate,
    output ihit, imemload, iREN, iaddr
  );

  // Datapath + memory controller end.
  modport master (
    output imemREN, imemaddr, iwait, iload, invalidate,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped I-cache: zero-cycle hits, single-word blocking fill on miss.
module icache_responder
  import icache_pkg::*;
(
  input logic                CLK,
  input logic                RST,
  icache_responder_if.slave  bus
);

  icache_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  icache_frame_t       frames_q [NSETS];
  icache_frame_t       frames_d [NSETS];

  logic [ADDR_W-1:0]   addr_al;
  icache_frame_t       look;
  logic                hit;

  // Lookup on the word-aligned fetch address; only meaningful while IDLE.
  always_comb begin
    addr_al = bus.imemaddr & ~ADDR_W'(3);
    look    = frames_q[get_idx(addr_al)];
    hit     = (state_q == IDLE) && bus.imemREN && look.valid &&
              (look.tag == get_tag(addr_al));
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? look.data : '0;
  assign bus.iREN     = (state_q == MISS);
  assign bus.iaddr    = (state_q == MISS) ? miss_addr_q : '0;

  // Next state, miss latch and frame updates; invalidate is applied last so
  // it also beats a fill landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    frames_d    = frames_q;
    case (state_q)
      IDLE: begin
        if (bus.imemREN && !hit && !bus.invalidate) begin
          state_d     = MISS;
          miss_addr_d = addr_al;
        end
      end
      MISS: begin
        if (!bus.iwait) begin
          state_d = IDLE;
          frames_d[get_idx(miss_addr_q)] = '{valid: 1'b1,
                                             tag:   get_tag(miss_addr_q),
                                             data:  bus.iload};
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.invalidate) begin
      for (int i = 0; i < NSETS; i++) frames_d[i].valid = 1'b0;
    end
  end

  // State, miss address and frame storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      for (int i = 0; i < NSETS; i++) frames_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed vector table, reset-mid-miss sequence,
// then random traffic against a cache-contents reference model.
module tb_icache_responder;
  import icache_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  icache_responder_if bus();

  icache_responder dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: what each set holds, and the outstanding request (if any).
  bit          m_v [NSETS];
  logic [31:0] m_t [NSETS];
  logic [31:0] m_d [NSETS];
  bit          m_busy;
  logic [31:0] m_a;

  typedef struct {
    bit ren; logic [31:0] addr; bit wt; logic [31:0] ld; bit inv;
    bit e_hit; logic [31:0] e_load; bit e_ren; logic [31:0] e_addr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NSETS; i++) begin m_v[i] = 0; m_t[i] = 0; m_d[i] = 0; end
    m_busy = 0; m_a = 0;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % NSETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (2 + IDX_W);
  endfunction

  function automatic void add(input bit ren, input logic [31:0] addr, input bit wt,
                              input logic [31:0] ld, input bit inv, input bit eh,
                              input logic [31:0] el, input bit er, input logic [31:0] ea);
    tbl.push_back('{ren, addr, wt, ld, inv, eh, el, er, ea});
  endfunction

  // One clock: drive, check against model mid-cycle, clock edge, advance model.
  task automatic step(input bit ren, input logic [31:0] addr, input bit wt,
                      input logic [31:0] ld, input bit inv,
                      output bit o_hit, output logic [31:0] o_load,
                      output bit o_ren, output logic [31:0] o_addr);
    bit          e_hit;
    logic [31:0] e_load;
    int          s;
    bus.imemREN = ren; bus.imemaddr = addr; bus.iwait = wt;
    bus.iload = ld; bus.invalidate = inv;
    #4;
    s      = set_of(addr);
    e_hit  = !m_busy && ren && m_v[s] && (m_t[s] == tag_of(addr));
    e_load = e_hit ? m_d[s] : 32'h0;
    o_hit = bus.ihit; o_load = bus.imemload; o_ren = bus.iREN; o_addr = bus.iaddr;
    chk("model ihit", {31'h0, o_hit}, {31'h0, e_hit});
    chk("model imemload", o_load, e_load);
    chk("model iREN", {31'h0, o_ren}, {31'h0, m_busy});
    if (m_busy) chk("model iaddr", o_addr, m_a);
    @(posedge CLK);
    if (m_busy) begin
      if (!wt) begin
        s = set_of(m_a);
        m_v[s] = !inv; m_t[s] = tag_of(m_a); m_d[s] = ld;
        m_busy = 0;
      end
    end else if (ren && !e_hit && !inv) begin
      m_busy = 1;
      m_a    = addr & ~32'h3;
    end
    if (inv) for (int i = 0; i < NSETS; i++) m_v[i] = 0;
    #1;
  endtask

  initial begin
    bit h, r; logic [31:0] l, a;
    bus.imemREN = 0; bus.imemaddr = 0; bus.iwait = 1; bus.iload = 0; bus.invalidate = 0;
    model_clear();
    #1;
    chk("reset ihit", {31'h0, bus.ihit}, 32'h0);
    chk("reset iREN", {31'h0, bus.iREN}, 32'h0);
    chk("reset iaddr", bus.iaddr, 32'h0);
    chk("reset imemload", bus.imemload, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 0;

    // Cold miss with 3 wait cycles, offset ignored on refetch.
    add(1,'h100,1,0,0, 0,0,0,0);
    add(1,'h100,1,0,0, 0,0,1,'h100);
    add(1,'h100,1,0,0, 0,0,1,'h100);
    add(1,'h100,1,0,0, 0,0,1,'h100);
    add(1,'h100,0,'hDEADBEEF,0, 0,0,1,'h100);
    add(1,'h100,1,0,0, 1,'hDEADBEEF,0,0);
    add(1,'h102,1,0,0, 1,'hDEADBEEF,0,0);
    // Conflict eviction in set 0.
    add(1,'h140,1,0,0, 0,0,0,0);
    add(1,'h140,0,'h12345678,0, 0,0,1,'h140);
    add(1,'h140,1,0,0, 1,'h12345678,0,0);
    add(1,'h100,1,0,0, 0,0,0,0);
    add(1,'h100,0,'hDEADBEEF,0, 0,0,1,'h100);
    add(1,'h100,1,0,0, 1,'hDEADBEEF,0,0);
    // Redirect mid-miss: 0x200 fill completes with imemREN low and addr 0x300.
    add(1,'h200,1,0,0, 0,0,0,0);
    add(0,'h300,1,0,0, 0,0,1,'h200);
    add(0,'h300,1,0,0, 0,0,1,'h200);
    add(1,'h300,0,'hCAFE0200,0, 0,0,1,'h200);
    add(1,'h300,1,0,0, 0,0,0,0);
    add(1,'h300,0,'hCAFE0300,0, 0,0,1,'h300);
    add(1,'h300,1,0,0, 1,'hCAFE0300,0,0);
    // 0x300 shares set 0 with 0x200, so 0x200 refills before hitting again.
    add(1,'h200,1,0,0, 0,0,0,0);
    add(1,'h200,0,'hCAFE0200,0, 0,0,1,'h200);
    add(1,'h200,1,0,0, 1,'hCAFE0200,0,0);
    // Invalidate on the fill cycle: request ends, frame stays invalid.
    add(1,'h400,1,0,0, 0,0,0,0);
    add(1,'h400,0,'h44,1, 0,0,1,'h400);
    add(1,'h400,1,0,0, 0,0,0,0);
    add(1,'h400,0,'h44,0, 0,0,1,'h400);
    add(1,'h400,1,0,0, 1,'h44,0,0);
    // Invalidate in IDLE together with a hit: hit now, miss next cycle.
    add(1,'h104,1,0,0, 0,0,0,0);
    add(1,'h104,0,'h11110104,0, 0,0,1,'h104);
    add(1,'h104,1,0,1, 1,'h11110104,0,0);
    add(1,'h104,1,0,0, 0,0,0,0);
    add(1,'h104,0,'h11110104,0, 0,0,1,'h104);
    add(1,'h104,1,0,0, 1,'h11110104,0,0);
    // Hit timing follows imemREN.
    add(0,'h104,1,0,0, 0,0,0,0);
    add(1,'h104,1,0,0, 1,'h11110104,0,0);
    add(0,'h104,1,0,0, 0,0,0,0);
    add(1,'h107,1,0,0, 1,'h11110104,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].ren, tbl[i].addr, tbl[i].wt, tbl[i].ld, tbl[i].inv, h, l, r, a);
      chk($sformatf("vec%0d ihit", i), {31'h0, h}, {31'h0, tbl[i].e_hit});
      chk($sformatf("vec%0d imemload", i), l, tbl[i].e_load);
      chk($sformatf("vec%0d iREN", i), {31'h0, r}, {31'h0, tbl[i].e_ren});
      if (tbl[i].e_ren) chk($sformatf("vec%0d iaddr", i), a, tbl[i].e_addr);
    end

    // Reset asserted mid-miss: outputs drop immediately, cache comes back cold.
    step(1,'h500,1,0,0, h,l,r,a);
    step(1,'h500,1,0,0, h,l,r,a);
    bus.iwait = 1;
    #2 RST = 1;
    #1;
    chk("rst-mid ihit", {31'h0, bus.ihit}, 32'h0);
    chk("rst-mid iREN", {31'h0, bus.iREN}, 32'h0);
    chk("rst-mid iaddr", bus.iaddr, 32'h0);
    chk("rst-mid imemload", bus.imemload, 32'h0);
    @(posedge CLK);
    #1 RST = 0;
    model_clear();
    step(1,'h104,1,0,0, h,l,r,a);
    chk("post-rst 0x104 miss", {31'h0, h}, 32'h0);
    step(1,'h104,1,0,0, h,l,r,a);
    chk("post-rst iREN", {31'h0, r}, 32'h1);
    chk("post-rst iaddr", a, 32'h104);

    // Random traffic over 4 sets x 4 tags, random wait states and flushes.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0,3) << 6) | ($urandom_range(0,3) << 2) | $urandom_range(0,3);
      step($urandom_range(0,3) != 0, ra, $urandom_range(0,4) < 3, $urandom,
           $urandom_range(0,19) == 0, h, l, r, a);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
